// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized RXD -> {data, parity err, framing err} valid/ready stream.
// Latency: rx_vld rises the cycle after the mid-point sample of the last stop bit.
// Backpressure: one-entry holding register; a character completing while it is full and not draining is dropped (ovr pulse).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_div[CW-1:0]       bit period minus one in clk cycles (>= 3), latched at start detect
//   RXD                   asynchronous serial line, idle high
//   rx_vld/rx_rdy         character stream handshake
//   rx_dat[DW-1:0]        received character
//   rx_err_par/rx_err_frm per-character status, qualified by rx_vld
//   ovr                   one-cycle pulse when a completed character was discarded
//   busy                  receiver is inside a frame
module uart_rx #(
    parameter int    DW     = 8,
    parameter int    SW     = 1,
    parameter string PARITY = "NONE",
    parameter int    CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cfg_div,
    input  logic          RXD,
    output logic          rx_vld,
    input  logic          rx_rdy,
    output logic [DW-1:0] rx_dat,
    output logic          rx_err_par,
    output logic          rx_err_frm,
    output logic          ovr,
    output logic          busy
);

    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");
    localparam int IW      = $clog2(DW);

    localparam logic [IW-1:0] LAST_BIT  = IW'(DW - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(SW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and falling-edge history
    // ------------------------------------------------------------------
    logic       rxd_s1_q, rxd_s2_q, rxd_hist_q;
    logic [1:0] warm_q;
    logic       armed_q;

    // warm_q marks when rxd_s2_q holds a real line sample rather than its
    // reset value. The detector only arms once a genuine 1 has been seen,
    // so a line held low through reset is not taken as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_hist_q <= 1'b1;
            warm_q     <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_hist_q <= rxd_s2_q;
            warm_q     <= {warm_q[0], 1'b1};
            armed_q    <= armed_q | (warm_q[1] & rxd_s2_q);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          commit;
    logic          frm_now;

    logic samp;
    logic tick;
    logic start_det;

    assign samp      = rxd_s2_q;
    assign tick      = (cnt_q == '0);
    assign start_det = armed_q & rxd_hist_q & ~rxd_s2_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        commit  = 1'b0;
        frm_now = ferr_q | ~samp;

        if (state_q == ST_IDLE) begin
            if (start_det) begin
                // First sample lands mid start bit, hence the half-period load.
                div_d   = cfg_div;
                cnt_d   = cfg_div >> 1;
                idx_d   = '0;
                dat_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                state_d = ST_START;
            end
        end else if (!tick) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = div_q;
            unique case (state_q)
                ST_START: begin
                    // A high sample means the low level was a glitch.
                    state_d = samp ? ST_IDLE : ST_DATA;
                    idx_d   = '0;
                end
                ST_DATA: begin
                    // LSB first: after DW shifts the first bit sits in bit 0.
                    dat_d = {samp, dat_q[DW-1:1]};
                    if (idx_q == LAST_BIT) begin
                        idx_d   = '0;
                        state_d = PAR_EN ? ST_PAR : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_PAR: begin
                    // Error when line bit differs from ^dat (EVEN) or ~^dat (ODD).
                    perr_d  = samp ^ (^dat_q) ^ PAR_ODD;
                    idx_d   = '0;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    ferr_d = frm_now;
                    if (idx_q == LAST_STOP) begin
                        commit  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and status outputs
    // ------------------------------------------------------------------
    logic          rx_vld_q;
    logic [DW-1:0] rx_dat_q;
    logic          rx_err_par_q, rx_err_frm_q;
    logic          ovr_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_vld_q     <= 1'b0;
            rx_dat_q     <= '0;
            rx_err_par_q <= 1'b0;
            rx_err_frm_q <= 1'b0;
            ovr_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ovr_q  <= 1'b0;
            busy_q <= (state_d != ST_IDLE);
            if (commit) begin
                // A draining entry frees the slot in the same cycle.
                if (!rx_vld_q || rx_rdy) begin
                    rx_vld_q     <= 1'b1;
                    rx_dat_q     <= dat_q;
                    rx_err_par_q <= perr_q;
                    rx_err_frm_q <= frm_now;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (rx_rdy) begin
                rx_vld_q <= 1'b0;
            end
        end
    end

    assign rx_vld     = rx_vld_q;
    assign rx_dat     = rx_dat_q;
    assign rx_err_par = rx_err_par_q;
    assign rx_err_frm = rx_err_frm_q;
    assign ovr        = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: four receivers (8N1, 8E1, 8O1, 5N2) each on its own line.
// Latency: checks exact rx_vld/busy timing on one frame, then table-driven frames.
// Backpressure: overrun and same-cycle transfer/commit exercised on the 8N1 lane.
module tb_uart_rx;

    localparam int DIV = 15;
    localparam int BP  = DIV + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_div = 16'(DIV);
    logic [3:0]  rxd = 4'hF;
    logic [3:0]  rdy = 4'hF;

    wire  [3:0]  vld, epar, efrm, ovr, busy;
    wire  [7:0]  dat0, dat1, dat2;
    wire  [4:0]  dat3;

    always #5 clk = ~clk;

    uart_rx #(.DW(8), .SW(1), .PARITY("NONE"), .CW(16)) u_n81 (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .RXD(rxd[0]),
        .rx_vld(vld[0]), .rx_rdy(rdy[0]), .rx_dat(dat0),
        .rx_err_par(epar[0]), .rx_err_frm(efrm[0]), .ovr(ovr[0]), .busy(busy[0]));
    uart_rx #(.DW(8), .SW(1), .PARITY("EVEN"), .CW(16)) u_e81 (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .RXD(rxd[1]),
        .rx_vld(vld[1]), .rx_rdy(rdy[1]), .rx_dat(dat1),
        .rx_err_par(epar[1]), .rx_err_frm(efrm[1]), .ovr(ovr[1]), .busy(busy[1]));
    uart_rx #(.DW(8), .SW(1), .PARITY("ODD"), .CW(16)) u_o81 (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .RXD(rxd[2]),
        .rx_vld(vld[2]), .rx_rdy(rdy[2]), .rx_dat(dat2),
        .rx_err_par(epar[2]), .rx_err_frm(efrm[2]), .ovr(ovr[2]), .busy(busy[2]));
    uart_rx #(.DW(5), .SW(2), .PARITY("NONE"), .CW(16)) u_n52 (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .RXD(rxd[3]),
        .rx_vld(vld[3]), .rx_rdy(rdy[3]), .rx_dat(dat3),
        .rx_err_par(epar[3]), .rx_err_frm(efrm[3]), .ovr(ovr[3]), .busy(busy[3]));

    int checks = 0;
    int errors = 0;

    // Transfer / overrun log per lane, sampled on the accepting edge.
    int         xcnt [4];
    int         ocnt [4];
    logic [7:0] ldat [4];
    logic       lpar [4];
    logic       lfrm [4];

    function automatic logic [7:0] dat_of(input logic [1:0] i);
        case (i)
            2'd0:    return dat0;
            2'd1:    return dat1;
            2'd2:    return dat2;
            default: return {3'b000, dat3};
        endcase
    endfunction

    function automatic logic bit_of(input logic [7:0] v, input int i);
        logic [7:0] t;
        t = v >> i;
        return t[0];
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            xcnt[i] = 0; ocnt[i] = 0; ldat[i] = 8'h00; lpar[i] = 1'b0; lfrm[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && rdy[i]) begin
                xcnt[i] = xcnt[i] + 1;
                ldat[i] = dat_of(2'(i));
                lpar[i] = epar[i];
                lfrm[i] = efrm[i];
            end
            if (ovr[i]) ocnt[i] = ocnt[i] + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Drive lane ln to v and hold it for n cycles; called at a negedge.
    task automatic hold(input logic [1:0] ln, input logic v, input int n);
        rxd[ln] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] ln, input int nb, input logic [7:0] d,
                        input logic hp, input logic pb, input int ns, input logic [1:0] st);
        hold(ln, 1'b0, BP);
        for (int i = 0; i < nb; i++) hold(ln, bit_of(d, i), BP);
        if (hp) hold(ln, pb, BP);
        for (int s = 0; s < ns; s++) hold(ln, bit_of({6'b0, st}, s), BP);
        rxd[ln] = 1'b1;
    endtask

    typedef struct {
        logic [1:0] ln;
        int         nb;
        logic [7:0] d;
        logic       hp;
        logic       pb;
        int         ns;
        logic [1:0] st;   // stop-bit levels, bit 0 sent first
        logic [7:0] xd;
        logic       xp;
        logic       xf;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, o0, first_v, nv, b_rise, b_fall, bi;
        logic saw;
        logic [7:0] d55;

        tbl[0]  = '{2'd0, 8, 8'h55, 1'b0, 1'b0, 1, 2'b11, 8'h55, 1'b0, 1'b0};
        tbl[1]  = '{2'd1, 8, 8'hA3, 1'b1, 1'b0, 1, 2'b11, 8'hA3, 1'b0, 1'b0};
        tbl[2]  = '{2'd1, 8, 8'hA3, 1'b1, 1'b1, 1, 2'b11, 8'hA3, 1'b1, 1'b0};
        tbl[3]  = '{2'd2, 8, 8'h00, 1'b1, 1'b1, 1, 2'b11, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{2'd2, 8, 8'h00, 1'b1, 1'b0, 1, 2'b11, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{2'd2, 8, 8'h07, 1'b1, 1'b0, 1, 2'b11, 8'h07, 1'b0, 1'b0};
        tbl[6]  = '{2'd0, 8, 8'hF0, 1'b0, 1'b0, 1, 2'b10, 8'hF0, 1'b0, 1'b1};
        tbl[7]  = '{2'd3, 5, 8'h15, 1'b0, 1'b0, 2, 2'b11, 8'h15, 1'b0, 1'b0};
        tbl[8]  = '{2'd3, 5, 8'h0A, 1'b0, 1'b0, 2, 2'b01, 8'h0A, 1'b0, 1'b1};
        tbl[9]  = '{2'd1, 8, 8'hFF, 1'b1, 1'b0, 1, 2'b10, 8'hFF, 1'b0, 1'b1};
        tbl[10] = '{2'd1, 8, 8'h5A, 1'b1, 1'b0, 1, 2'b11, 8'h5A, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_vld", int'(vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_errs", int'({epar, efrm}), 0);
        chk("rst_dat", int'({dat0, dat1, dat2, dat3}), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // ---------------- exact timing, 0x55 on 8N1 ----------------
        d55 = 8'h55;
        c0 = xcnt[0];
        first_v = -1; nv = 0; b_rise = -1; b_fall = -1;
        rxd[0] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (vld[0]) begin
                nv = nv + 1;
                if (first_v < 0) first_v = k;
            end
            if (busy[0] && b_rise < 0) b_rise = k;
            if (!busy[0] && b_rise >= 0 && b_fall < 0) b_fall = k;
            bi = (k + 1) / BP;
            rxd[0] = (bi == 0) ? 1'b0 : (bi <= 8) ? bit_of(d55, bi - 1) : 1'b1;
            if (k == 40) cfg_div = 16'd7;    // must not disturb the frame in flight
            if (k == 180) cfg_div = 16'(DIV);
        end
        chk("tim_vld_rise", first_v, 154);
        chk("tim_vld_width", nv, 1);
        chk("tim_busy_rise", b_rise, 2);
        chk("tim_busy_fall", b_fall, 154);
        chk("tim_xfer", xcnt[0] - c0, 1);
        chk("tim_dat", int'(ldat[0]), 'h55);
        chk("tim_errs", int'({lpar[0], lfrm[0]}), 0);
        @(negedge clk);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 11; i++) begin
            c0 = xcnt[tbl[i].ln];
            o0 = ocnt[tbl[i].ln];
            send(tbl[i].ln, tbl[i].nb, tbl[i].d, tbl[i].hp, tbl[i].pb, tbl[i].ns, tbl[i].st);
            hold(tbl[i].ln, 1'b1, BP);
            chk($sformatf("v%0d_xfer", i), xcnt[tbl[i].ln] - c0, 1);
            chk($sformatf("v%0d_dat", i), int'(ldat[tbl[i].ln]), int'(tbl[i].xd));
            chk($sformatf("v%0d_par", i), int'(lpar[tbl[i].ln]), int'(tbl[i].xp));
            chk($sformatf("v%0d_frm", i), int'(lfrm[tbl[i].ln]), int'(tbl[i].xf));
            chk($sformatf("v%0d_ovr", i), ocnt[tbl[i].ln] - o0, 0);
        end

        // ---------------- glitch -> false start, then 0x3C ----------------
        c0 = xcnt[0];
        saw = 1'b0;
        hold(2'd0, 1'b0, 3);
        rxd[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy[0]) saw = 1'b1;
        end
        chk("glitch_seen", int'(saw), 1);
        chk("glitch_busy", int'(busy[0]), 0);
        chk("glitch_xfer", xcnt[0] - c0, 0);
        send(2'd0, 8, 8'h3C, 1'b0, 1'b0, 1, 2'b11);
        hold(2'd0, 1'b1, BP);
        chk("glitch_next_xfer", xcnt[0] - c0, 1);
        chk("glitch_next_dat", int'(ldat[0]), 'h3C);
        chk("glitch_next_frm", int'(lfrm[0]), 0);

        // ---------------- break ----------------
        c0 = xcnt[0];
        hold(2'd0, 1'b0, 20 * BP);
        chk("brk_xfer", xcnt[0] - c0, 1);
        chk("brk_dat", int'(ldat[0]), 0);
        chk("brk_frm", int'(lfrm[0]), 1);
        chk("brk_par", int'(lpar[0]), 0);
        hold(2'd0, 1'b1, 2 * BP);
        chk("brk_no_second", xcnt[0] - c0, 1);
        send(2'd0, 8, 8'hC5, 1'b0, 1'b0, 1, 2'b11);
        hold(2'd0, 1'b1, BP);
        chk("brk_after_xfer", xcnt[0] - c0, 2);
        chk("brk_after_dat", int'(ldat[0]), 'hC5);
        chk("brk_after_frm", int'(lfrm[0]), 0);

        // ---------------- overrun / back-pressure ----------------
        rdy[0] = 1'b0;
        c0 = xcnt[0];
        o0 = ocnt[0];
        send(2'd0, 8, 8'h11, 1'b0, 1'b0, 1, 2'b11);
        send(2'd0, 8, 8'h22, 1'b0, 1'b0, 1, 2'b11);
        hold(2'd0, 1'b1, BP);
        chk("ovr_vld", int'(vld[0]), 1);
        chk("ovr_keep_old", int'(dat0), 'h11);
        chk("ovr_pulses", ocnt[0] - o0, 1);
        chk("ovr_no_xfer", xcnt[0] - c0, 0);
        fork
            send(2'd0, 8, 8'h33, 1'b0, 1'b0, 1, 2'b11);
            begin
                @(posedge clk);              // first edge capturing the start bit
                repeat (153) @(posedge clk);
                @(negedge clk) rdy[0] = 1'b1; // spans exactly the commit edge
                @(negedge clk) rdy[0] = 1'b0;
            end
        join
        hold(2'd0, 1'b1, BP);
        chk("same_cyc_xfer", xcnt[0] - c0, 1);
        chk("same_cyc_old_dat", int'(ldat[0]), 'h11);
        chk("same_cyc_vld", int'(vld[0]), 1);
        chk("same_cyc_new_dat", int'(dat0), 'h33);
        chk("same_cyc_no_ovr", ocnt[0] - o0, 1);

        // ---------------- reset mid-frame on 5N2, line low through reset on 8O1 ----------------
        hold(2'd3, 1'b0, BP);
        for (int i = 0; i < 4; i++) hold(2'd3, 1'b1, BP);
        hold(2'd3, 1'b1, 8);                 // middle of data bit 4
        chk("mid_busy", int'(busy[3]), 1);
        rxd[2] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", int'(vld), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_dat", int'(dat0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = xcnt[2];
        saw = 1'b0;
        for (int k = 0; k < 3 * BP; k++) begin
            @(negedge clk);
            if (busy[2] || busy[3]) saw = 1'b1;
        end
        chk("low_thru_rst_busy", int'(saw), 0);
        rxd[2] = 1'b1;
        hold(2'd3, 1'b1, BP);
        chk("low_thru_rst_xfer", xcnt[2] - c0, 0);
        c0 = xcnt[3];
        send(2'd3, 5, 8'h1F, 1'b0, 1'b0, 2, 2'b11);
        hold(2'd3, 1'b1, BP);
        chk("resume_xfer", xcnt[3] - c0, 1);
        chk("resume_dat", int'(ldat[3]), 'h1F);
        chk("resume_errs", int'({lpar[3], lfrm[3]}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
